execute_forward_n: RTL and testbench
====================================

EXECUTE_FORWARD_N -- requirements
Module: execute_forward_n

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits.
REQ-002 Parameter NSRC, default 2, range 1..4: number of source operands forwarded per instruction.
REQ-003 Parameter AW, default 5: register-address width.
REQ-004 Parameter FWD_EN, default 1: 1 = forwarding plus load-use stall; 0 = no forwarding, stall on every RAW hazard.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 rs_d  in  NSRC*AW  decode-stage source addresses; operand i is at bits [i*AW +: AW].
REQ-009 rd_d, regwrite_d, load_d, valid_d  in  AW,1,1,1  decode-stage destination address, write enable, load flag and valid.
REQ-010 rdata_e  in  NSRC*XLEN  register-file read data for the instruction in E.
REQ-011 alu_result_m, result_w  in  XLEN each  M-stage ALU result and W-stage writeback result.
REQ-012 branch_taken_e  in  1  redirect from E.
REQ-013 op_e  out  NSRC*XLEN  forwarded operands.
REQ-014 fwd_sel_e  out  NSRC*2  registered per-operand select.
REQ-015 stall_f, stall_d, flush_d, flush_e  out  1 each  pipeline control.
REQ-016 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-017 Shadow pipeline E/M/W of {rd, regwrite, load, valid} SHALL advance every clock: E<=D fields, M<=E, W<=M; E<=bubble (all zero) when flush_e=1.
REQ-018 A stage "writes r" only if valid, regwrite and rd==r and r!=0; address x0 SHALL never forward or stall.
REQ-019 fwd_sel_e[i] SHALL be registered at the D->E edge: 2'b10 if E-shadow writes rs_d[i] (it becomes M); else 2'b01 if M-shadow writes rs_d[i] (it becomes W); else 2'b00; held while stall_d=1; forced 2'b00 on flush_e or when FWD_EN=0.
REQ-020 op_e[i] SHALL be combinational: 00->rdata_e[i], 01->result_w, 10->alu_result_m, 11->rdata_e[i].
REQ-021 FWD_EN=1 load-use: E-shadow is load and writes any rs_d[i] with valid_d -> stall_f=stall_d=flush_e=1 for exactly one cycle; the dependent instruction then receives select 01.
REQ-022 FWD_EN=0: E- or M-shadow writes any rs_d[i] with valid_d -> stall_f=stall_d=flush_e=1, re-evaluated each cycle (1 or 2 stall cycles); W needs no stall because the register file is write-first.
REQ-023 branch_taken_e=1 SHALL assert flush_d=flush_e=1 and force stall_f=stall_d=0 in the same cycle; flush overrides a simultaneous stall.
REQ-024 Matches from several stages on one operand SHALL resolve to the youngest (M over W); different operands resolve independently.
REQ-025 stall_cnt SHALL increment on each cycle with stall_d=1 and saturate at 32'hFFFF_FFFF.

Reset
REQ-026 With rst_n low, all shadow stages SHALL be bubbles, fwd_sel_e=0, stall_cnt=0 and all stall/flush outputs 0, without waiting for a clock edge.
REQ-027 Reset asserted mid-stall SHALL cancel the stall; the first cycle after release SHALL show no hazard.

Structure
REQ-028 Shared package fwd_pkg SHALL hold the select encodings FWD_RF=2'b00, FWD_W=2'b01 and FWD_M=2'b10, plus the shadow-stage record type.
REQ-029 One sub-module, fwd_operand_mux (XLEN-wide 4:1 operand mux), SHALL be instantiated NSRC times through generate.

Verification
REQ-030 ADD x5 in E, next instruction reads x5 -> fwd_sel_e[0]=10 and op_e[0]=alu_result_m=32'h1234.
REQ-031 LW x7, then an instruction reading x7 in operand 1 -> one stall cycle with flush_e=1, then fwd_sel_e[1]=01 and op_e[1]=result_w.
REQ-032 Write to x0 in E, next instruction reads x0 -> select 00, no stall.
REQ-033 Load-use hazard coincident with branch_taken_e=1 -> flush_d=flush_e=1, stall_d=0, stall_cnt unchanged.
REQ-034 FWD_EN=0, ADD x3, then an instruction reading x3 -> two stall cycles, select 00, stall_cnt advances by 2.
REQ-035 rst_n pulsed low during a stall -> outputs cleared asynchronously, stall_cnt=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the execute-stage forwarding block: operand select
// encodings, the shadow-stage record and a small match helper.
package fwd_pkg;

    // Operand select encodings (2'b11 falls back to the register file)
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Destination addresses are stored zero-extended to this width so the
    // record type can live in the package independent of AW (AW <= 8).
    localparam int RD_MAX_W = 8;

    // One shadow pipeline stage: what the instruction in that stage will write
    typedef struct packed {
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                load;
        logic                valid;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    // A stage writes register r only when it is a valid register-writing
    // instruction targeting r, and r is not the hardwired zero register.
    function automatic logic stage_writes(
        input logic                valid,
        input logic                regwrite,
        input logic [RD_MAX_W-1:0] rd,
        input logic [RD_MAX_W-1:0] r
    );
        return valid && regwrite && (rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// XLEN-wide 4:1 operand mux choosing between register-file data and the
// M/W bypass values according to a registered forwarding select.
module fwd_operand_mux #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] w_data,
    input  logic [XLEN-1:0] m_data,
    output logic [XLEN-1:0] op
);
    import fwd_pkg::*;

    // Pick the bypass source; the unused 2'b11 code reads the register file
    always_comb begin
        op = rf_data;
        case (sel)
            FWD_W:   op = w_data;
            FWD_M:   op = m_data;
            default: op = rf_data;
        endcase
    end

endmodule

// File: rtl/execute_forward_n.sv
// Execute-stage forwarding and hazard unit. Tracks a shadow E/M/W pipeline
// of destination info, registers a per-operand bypass select at the D->E
// edge, and raises stall/flush controls for load-use (or, without
// forwarding, any RAW) hazards and for taken branches.
module execute_forward_n #(
    parameter int XLEN   = 32,
    parameter int NSRC   = 2,
    parameter int AW     = 5,
    parameter int FWD_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   rs_d,
    input  logic [AW-1:0]        rd_d,
    input  logic                 regwrite_d,
    input  logic                 load_d,
    input  logic                 valid_d,
    input  logic [NSRC*XLEN-1:0] rdata_e,
    input  logic [XLEN-1:0]      alu_result_m,
    input  logic [XLEN-1:0]      result_w,
    input  logic                 branch_taken_e,
    output logic [NSRC*XLEN-1:0] op_e,
    output logic [NSRC*2-1:0]    fwd_sel_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [31:0]          stall_cnt
);
    import fwd_pkg::*;

    shadow_t e_q, e_d;
    shadow_t m_q, m_d;
    shadow_t w_q, w_d;

    logic [NSRC*2-1:0] fwd_sel_q, fwd_sel_d;
    logic [NSRC*2-1:0] sel_cand;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic load_use_hit;
    logic raw_hit;
    logic hazard;
    logic stall_int;
    logic flush_e_int;

    // The W record ends the shadow pipe; the register file is write-first,
    // so no hazard logic consumes it and it is folded into a named sink.
    logic w_shadow_unused;
    assign w_shadow_unused = ^w_q;

    // Compare each decode source against E and M; E is the younger stage and wins
    always_comb begin
        sel_cand     = '0;
        load_use_hit = 1'b0;
        raw_hit      = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (stage_writes(e_q.valid, e_q.regwrite, e_q.rd,
                             RD_MAX_W'(rs_d[i*AW +: AW]))) begin
                sel_cand[i*2 +: 2] = FWD_M;
                raw_hit            = raw_hit | valid_d;
                load_use_hit       = load_use_hit | (valid_d & e_q.load);
            end else if (stage_writes(m_q.valid, m_q.regwrite, m_q.rd,
                                      RD_MAX_W'(rs_d[i*AW +: AW]))) begin
                sel_cand[i*2 +: 2] = FWD_W;
                raw_hit            = raw_hit | valid_d;
            end
        end
    end

    // Stall/flush decisions; a taken branch cancels any stall, and all
    // controls drop immediately while reset is held
    always_comb begin
        hazard      = (FWD_EN != 0) ? load_use_hit : raw_hit;
        stall_int   = rst_n & hazard & ~branch_taken_e;
        flush_e_int = rst_n & (hazard | branch_taken_e);
    end

    assign stall_f   = stall_int;
    assign stall_d   = stall_int;
    assign flush_e   = flush_e_int;
    assign flush_d   = rst_n & branch_taken_e;
    assign fwd_sel_e = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state: shadow advance, select capture, saturating stall counter
    always_comb begin
        e_d = SHADOW_BUBBLE;
        if (!flush_e_int) begin
            e_d.rd       = RD_MAX_W'(rd_d);
            e_d.regwrite = regwrite_d;
            e_d.load     = load_d;
            e_d.valid    = valid_d;
        end
        m_d = e_q;
        w_d = m_q;

        fwd_sel_d = fwd_sel_q;
        if (!stall_int) begin
            if (flush_e_int || (FWD_EN == 0)) begin
                fwd_sel_d = '0;
            end else begin
                fwd_sel_d = sel_cand;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= SHADOW_BUBBLE;
            m_q         <= SHADOW_BUBBLE;
            w_q         <= SHADOW_BUBBLE;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // One operand mux per source, driven by the registered select
    for (genvar g = 0; g < NSRC; g++) begin : g_op
        fwd_operand_mux #(
            .XLEN(XLEN)
        ) u_mux (
            .sel     (fwd_sel_q[g*2 +: 2]),
            .rf_data (rdata_e[g*XLEN +: XLEN]),
            .w_data  (result_w),
            .m_data  (alu_result_m),
            .op      (op_e[g*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_execute_forward_n.sv
// Self-checking bench: one forwarding instance and one non-forwarding
// instance share the same stimulus and are compared every cycle against an
// instruction-level reference model.
module tb_execute_forward_n;

    localparam int XLEN = 32;
    localparam int NSRC = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NSRC*AW-1:0]   rs_d;
    logic [AW-1:0]        rd_d;
    logic                 regwrite_d, load_d, valid_d;
    logic [NSRC*XLEN-1:0] rdata_e;
    logic [XLEN-1:0]      alu_result_m, result_w;
    logic                 branch_taken_e;

    logic [NSRC*XLEN-1:0] op_e1, op_e0;
    logic [NSRC*2-1:0]    sel1, sel0;
    logic                 sf1, sd1, fd1, fe1;
    logic                 sf0, sd0, fd0, fe0;
    logic [31:0]          cnt1, cnt0;

    execute_forward_n #(.XLEN(XLEN), .NSRC(NSRC), .AW(AW), .FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .load_d(load_d), .valid_d(valid_d),
        .rdata_e(rdata_e), .alu_result_m(alu_result_m), .result_w(result_w),
        .branch_taken_e(branch_taken_e), .op_e(op_e1), .fwd_sel_e(sel1),
        .stall_f(sf1), .stall_d(sd1), .flush_d(fd1), .flush_e(fe1),
        .stall_cnt(cnt1)
    );

    execute_forward_n #(.XLEN(XLEN), .NSRC(NSRC), .AW(AW), .FWD_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .load_d(load_d), .valid_d(valid_d),
        .rdata_e(rdata_e), .alu_result_m(alu_result_m), .result_w(result_w),
        .branch_taken_e(branch_taken_e), .op_e(op_e0), .fwd_sel_e(sel0),
        .stall_f(sf0), .stall_d(sd0), .flush_d(fd0), .flush_e(fe0),
        .stall_cnt(cnt0)
    );

    // Reference model: per configuration (index 1 = forwarding, 0 = none)
    // the three instructions currently past decode, youngest first.
    typedef struct {
        int rd;
        bit wr;
        bit ld;
        bit v;
    } instr_t;

    instr_t      pipeM [2][3];
    logic [1:0]  selM  [2][NSRC];
    logic [31:0] cntM  [2];

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes(instr_t s, int r);
        return s.v && s.wr && (s.rd == r) && (r != 0);
    endfunction

    function automatic int rsOf(int i);
        logic [AW-1:0] a;
        a = rs_d[i*AW +: AW];
        return int'(a);
    endfunction

    function automatic logic [NSRC*AW-1:0] rsPack(int a0, int a1);
        return {AW'(a1), AW'(a0)};
    endfunction

    // Hazard for the instruction sitting in decode under configuration c
    function automatic bit rawHazard(int c);
        bit h = 1'b0;
        if (!valid_d) return 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (c == 1) begin
                if (writes(pipeM[c][0], rsOf(i)) && pipeM[c][0].ld) h = 1'b1;
            end else begin
                if (writes(pipeM[c][0], rsOf(i)) || writes(pipeM[c][1], rsOf(i))) h = 1'b1;
            end
        end
        return h;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 3; s++) pipeM[c][s] = '{0, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < NSRC; i++) selM[c][i] = 2'b00;
            cntM[c] = 32'd0;
        end
    endtask

    // Compare every output of both instances against the model
    task automatic checkAll();
        bit          h, st, fe, fd;
        logic [63:0] opx;
        logic [3:0]  sx;
        for (int c = 0; c < 2; c++) begin
            h  = rawHazard(c);
            st = rst_n && h && !branch_taken_e;
            fe = rst_n && (h || branch_taken_e);
            fd = rst_n && branch_taken_e;
            opx = '0;
            sx  = '0;
            for (int i = 0; i < NSRC; i++) begin
                sx[i*2 +: 2] = selM[c][i];
                if (selM[c][i] == 2'b10)      opx[i*32 +: 32] = alu_result_m;
                else if (selM[c][i] == 2'b01) opx[i*32 +: 32] = result_w;
                else                          opx[i*32 +: 32] = rdata_e[i*XLEN +: XLEN];
            end
            if (c == 1) begin
                checkOutput("stall_f_fwd", 64'(sf1), 64'(st));
                checkOutput("stall_d_fwd", 64'(sd1), 64'(st));
                checkOutput("flush_d_fwd", 64'(fd1), 64'(fd));
                checkOutput("flush_e_fwd", 64'(fe1), 64'(fe));
                checkOutput("sel_fwd",     64'(sel1), 64'(sx));
                checkOutput("op_fwd",      64'(op_e1), opx);
                checkOutput("cnt_fwd",     64'(cnt1), 64'(cntM[1]));
            end else begin
                checkOutput("stall_f_nofwd", 64'(sf0), 64'(st));
                checkOutput("stall_d_nofwd", 64'(sd0), 64'(st));
                checkOutput("flush_d_nofwd", 64'(fd0), 64'(fd));
                checkOutput("flush_e_nofwd", 64'(fe0), 64'(fe));
                checkOutput("sel_nofwd",     64'(sel0), 64'(sx));
                checkOutput("op_nofwd",      64'(op_e0), opx);
                checkOutput("cnt_nofwd",     64'(cnt0), 64'(cntM[0]));
            end
        end
    endtask

    // Advance the model on the same rising edge the DUTs see
    task automatic clockEdge();
        bit     h, st, fe;
        instr_t dec;
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
        end else begin
            dec = '{int'(rd_d), regwrite_d, load_d, valid_d};
            for (int c = 0; c < 2; c++) begin
                h  = rawHazard(c);
                st = h && !branch_taken_e;
                fe = h || branch_taken_e;
                if (!st) begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (fe || c == 0)                      selM[c][i] = 2'b00;
                        else if (writes(pipeM[c][0], rsOf(i))) selM[c][i] = 2'b10;
                        else if (writes(pipeM[c][1], rsOf(i))) selM[c][i] = 2'b01;
                        else                                   selM[c][i] = 2'b00;
                    end
                end
                if (st && cntM[c] != 32'hFFFF_FFFF) cntM[c] = cntM[c] + 32'd1;
                pipeM[c][2] = pipeM[c][1];
                pipeM[c][1] = pipeM[c][0];
                pipeM[c][0] = fe ? '{0, 1'b0, 1'b0, 1'b0} : dec;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NSRC*AW-1:0] rs, input int rd,
                                 input bit wr, input bit ld, input bit v, input bit br);
        @(negedge clk);
        rs_d           = rs;
        rd_d           = AW'(rd);
        regwrite_d     = wr;
        load_d         = ld;
        valid_d        = v;
        branch_taken_e = br;
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(rsPack(0, 0), 0, 1'b0, 1'b0, 1'b0, 1'b0);
            clockEdge();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] saved;
        rst_n          = 1'b0;
        rs_d           = rsPack(0, 0);
        rd_d           = '0;
        regwrite_d     = 1'b1;
        load_d         = 1'b1;
        valid_d        = 1'b1;
        branch_taken_e = 1'b1;
        alu_result_m   = 32'h1234;
        result_w       = 32'h5678;
        rdata_e        = {32'hBBBB_0001, 32'hAAAA_0000};
        modelReset();
        $display("[TB] reset phase");

        #2;
        checkOutput("reset_flush_d", 64'(fd1), 64'd0);
        checkOutput("reset_flush_e", 64'(fe1), 64'd0);
        checkOutput("reset_cnt",     64'(cnt1), 64'd0);
        checkAll();
        clockEdge();
        clockEdge();
        #2 rst_n = 1'b1;

        $display("[TB] ALU forward from M");
        idle(3);
        applyStimulus(rsPack(0, 0), 5, 1'b1, 1'b0, 1'b1, 1'b0);
        clockEdge();
        applyStimulus(rsPack(5, 0), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("add_no_stall", 64'(sd1), 64'd0);
        clockEdge();
        #1;
        checkOutput("add_sel0", 64'(sel1[1:0]), 64'h2);
        checkOutput("add_op0",  64'(op_e1[31:0]), 64'h1234);

        $display("[TB] load-use on operand 1");
        idle(3);
        applyStimulus(rsPack(0, 0), 7, 1'b1, 1'b1, 1'b1, 1'b0);
        clockEdge();
        applyStimulus(rsPack(0, 7), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("lu_stall_d", 64'(sd1), 64'd1);
        checkOutput("lu_stall_f", 64'(sf1), 64'd1);
        checkOutput("lu_flush_e", 64'(fe1), 64'd1);
        clockEdge();
        applyStimulus(rsPack(0, 7), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("lu_released", 64'(sd1), 64'd0);
        clockEdge();
        #1;
        checkOutput("lu_sel1", 64'(sel1[3:2]), 64'h1);
        checkOutput("lu_op1",  64'(op_e1[63:32]), 64'h5678);

        $display("[TB] x0 never forwards");
        idle(3);
        applyStimulus(rsPack(0, 0), 0, 1'b1, 1'b1, 1'b1, 1'b0);
        clockEdge();
        applyStimulus(rsPack(0, 0), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("x0_stall_fwd",   64'(sd1), 64'd0);
        checkOutput("x0_stall_nofwd", 64'(sd0), 64'd0);
        clockEdge();
        #1;
        checkOutput("x0_sel", 64'(sel1), 64'd0);

        $display("[TB] load-use with taken branch");
        idle(3);
        applyStimulus(rsPack(0, 0), 7, 1'b1, 1'b1, 1'b1, 1'b0);
        clockEdge();
        saved = cntM[1];
        applyStimulus(rsPack(7, 0), 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("br_flush_d", 64'(fd1), 64'd1);
        checkOutput("br_flush_e", 64'(fe1), 64'd1);
        checkOutput("br_stall_d", 64'(sd1), 64'd0);
        checkOutput("br_stall_f", 64'(sf1), 64'd0);
        clockEdge();
        #1;
        checkOutput("br_cnt_held", 64'(cnt1), 64'(saved));

        $display("[TB] no-forward RAW stall");
        idle(3);
        applyStimulus(rsPack(0, 0), 3, 1'b1, 1'b0, 1'b1, 1'b0);
        clockEdge();
        saved = cntM[0];
        applyStimulus(rsPack(3, 0), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("nf_stall1", 64'(sd0), 64'd1);
        clockEdge();
        applyStimulus(rsPack(3, 0), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("nf_stall2", 64'(sd0), 64'd1);
        clockEdge();
        applyStimulus(rsPack(3, 0), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("nf_stall3", 64'(sd0), 64'd0);
        clockEdge();
        #1;
        checkOutput("nf_sel", 64'(sel0), 64'd0);
        checkOutput("nf_cnt", 64'(cnt0), 64'(saved + 32'd2));

        $display("[TB] reset during stall");
        idle(3);
        applyStimulus(rsPack(0, 0), 7, 1'b1, 1'b1, 1'b1, 1'b0);
        clockEdge();
        applyStimulus(rsPack(0, 7), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rs_pre_stall", 64'(sd1), 64'd1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rs_stall_d", 64'(sd1), 64'd0);
        checkOutput("rs_flush_e", 64'(fe1), 64'd0);
        checkOutput("rs_cnt",     64'(cnt1), 64'd0);
        checkOutput("rs_sel",     64'(sel1), 64'd0);
        checkAll();
        clockEdge();
        #2 rst_n = 1'b1;
        applyStimulus(rsPack(0, 7), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rs_after_release", 64'(sd1), 64'd0);
        clockEdge();

        $display("[TB] random phase");
        for (int n = 0; n < 400; n++) begin
            rdata_e      = {$urandom, $urandom};
            alu_result_m = $urandom;
            result_w     = $urandom;
            applyStimulus(rsPack($urandom_range(0, 7), $urandom_range(0, 7)),
                          $urandom_range(0, 7),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 9) == 0);
            if (n % 137 == 70) begin
                rst_n = 1'b0;
                modelReset();
                #1;
                checkAll();
                clockEdge();
                #2 rst_n = 1'b1;
            end else begin
                clockEdge();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
